branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch direction predictor for the five-stage pipeline. It looks up a table of 2-bit saturating counters in IF and carries each prediction through ID to EX alongside the instruction. In EX it compares the stored prediction with the resolved direction from the branch-control logic (func3 + ALU flags), updates the table and raises a one-cycle mispredict/redirect request. It produces the speculation that the EX-stage branch resolution confirms or corrects.

## Interface
- `ENTRIES`, 16: number of counters; power of two, 4..256.
- `IDX_W`, $clog2(ENTRIES): table index width (derived; not overridden).
- `CNT_W`, 16: width of statistics counters.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `if_pc`  in  32  PC of the instruction in IF.
- `if_valid`  in  1  IF holds a real instruction.
- `if_is_branch`  in  1  predecode: opcode == 7'b1100011.
- `stall`  in  1  load-use hold: IF/ID slot holds, ID/EX slot takes a bubble.
- `flush`  in  1  external flush (JAL/JALR/trap): clears both slots.
- `ex_branch`  in  1  EX-stage `branch` control bit.
- `ex_taken`  in  1  resolved direction from branch control.
- `pred_taken`  out  1  IF prediction, combinational.
- `mispredict`  out  1  EX prediction wrong, combinational.
- `redirect_to_target`  out  1  valid with `mispredict`: 1 = fetch branch target, 0 = fetch branch PC+4.
- `branch_count`  out  CNT_W  resolved branches, saturating.
- `mispredict_count`  out  CNT_W  mispredictions, saturating.

## Operation
- Index = `if_pc[IDX_W+1:2]`. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken when counter[1] = 1.
- `pred_taken` = `if_valid & if_is_branch & table[idx][1]`; otherwise 0.
- Pipeline slots `s_id` and `s_ex`, each holding {valid, is_br, pred, idx}. At each edge, in priority order:
  - `rst`: both slots are cleared. Every counter is set to 01. Both stat counters are set to 0.
  - `flush` or `mispredict`: both slots are cleared.
  - `stall`: `s_id` holds and `s_ex` is cleared (bubble).
  - Otherwise: `s_ex` <= `s_id`, and `s_id` <= {if_valid, if_is_branch, pred_taken, idx}.
- Resolution occurs when `ex_branch & s_ex.valid & s_ex.is_br`:
  - `mispredict` = `ex_taken ^ s_ex.pred`. `redirect_to_target` = `ex_taken`.
  - At the edge, `table[s_ex.idx]` increments (saturating at 11) if `ex_taken`, otherwise decrements (saturating at 00).
  - `branch_count` increments. `mispredict_count` increments if `mispredict`. Both saturate at all-ones.
- `ex_branch` with an invalid or non-branch `s_ex`: no table or stats update. `mispredict` = `ex_taken`, because the implicit prediction is not-taken.
- No resolution: `mispredict` = 0 and `redirect_to_target` = 0.
- `stall` does not block resolution. EX always completes.

## Timing
- Prediction latency is 0 cycles: `pred_taken` depends combinationally on `if_pc`.
- A prediction reaches EX 2 cycles after IF when there is no stall. Each stall cycle adds one cycle of ID residency.
- `mispredict` is valid in the EX cycle of the branch and lasts 1 cycle. The table write and slot clear happen at the end of that cycle.
- Same-cycle read/write to the same index: the IF lookup returns the pre-update value, so the new value is visible from the next cycle.
- A mispredict together with `flush` or `stall` in the same cycle: the flush wins, both slots clear, and the table is still updated.
- Reset asserted mid-operation: everything is restored to the reset values on that edge. All outputs reflect the cleared state in the following cycle, and no pending resolution is applied.
- All outputs are 0 during and immediately after reset. The exception is `pred_taken` for a valid branch, which reads 0 because the counters are 01.

## Test plan
- Reset, then a branch at PC 0x40 resolved taken 3 times consecutively → predictions 0, 1, 1. Counter[0x40>>2 & 15] walks 01→10→11→11. `mispredict` fires only on the first.
- Counter at 11, branch resolved not-taken → `mispredict`=1, `redirect_to_target`=0, counter becomes 10, and the next lookup still predicts taken.
- Branch at PC 0x10 with `stall` held 2 cycles while in IF/ID → the prediction reaches EX on cycle 4. Exactly one resolution is counted and `branch_count`=1.
- Mispredict in EX while `s_id` holds a branch → `s_id` is cleared. The next cycle shows `ex_branch` with an invalid slot, with no table update and `branch_count` unchanged.
- Aliasing: PC 0x04 and 0x44 with ENTRIES=16, where 0x44 is resolved taken while 0x04 is in IF the same cycle → 0x04 reads the old counter (01, predicts 0). The next read is 10 and predicts 1.
- Force `branch_count` to 0xFFFF, then resolve one more branch → it stays 0xFFFF. Assert `rst` mid-stream → all counters read 01 and both stats read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter direction predictor, looked up in IF and resolved in EX
// Ports: clk/rst (sync, active-high); if_pc/if_valid/if_is_branch give the IF lookup;
// stall/flush steer the IF/ID and ID/EX prediction slots; ex_branch/ex_taken resolve in EX;
// pred_taken is the IF prediction; mispredict/redirect_to_target request a refetch;
// branch_count/mispredict_count are saturating statistics.
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      if_pc,
   input  logic             if_valid,
   input  logic             if_is_branch,
   input  logic             stall,
   input  logic             flush,
   input  logic             ex_branch,
   input  logic             ex_taken,
   output logic             pred_taken,
   output logic             mispredict,
   output logic             redirect_to_target,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);
   localparam int SW = IDX_W + 3;
   logic [1:0]       tbl [ENTRIES];
   logic [SW-1:0]    s_id, s_ex;
   logic [IDX_W-1:0] idx, ex_idx;
   logic [1:0]       ex_cnt;
   logic             resolve, ex_pred;
   logic             unused_pc;
   assign unused_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0]};
   assign idx = if_pc[IDX_W+1:2];
   // slot layout: {valid, is_br, pred, idx}
   assign ex_idx  = s_ex[IDX_W-1:0];
   assign ex_pred = s_ex[IDX_W];
   assign ex_cnt  = tbl[ex_idx];
   assign resolve = ex_branch & s_ex[IDX_W+2] & s_ex[IDX_W+1];
   assign pred_taken = if_valid & if_is_branch & tbl[idx][1];
   // a branch seen in EX without a tracked prediction is treated as predicted not-taken
   assign mispredict = ex_branch & (ex_taken ^ (resolve & ex_pred));
   assign redirect_to_target = ex_branch & ex_taken;
   always_ff @(posedge clk) begin
      if (rst) begin
         s_id <= '0;
         s_ex <= '0;
         branch_count <= '0;
         mispredict_count <= '0;
         for (int i = 0; i < ENTRIES; i++) tbl[i] <= 2'b01;
      end else begin
         if (flush | mispredict) begin
            s_id <= '0;
            s_ex <= '0;
         end else if (stall) begin
            s_ex <= '0;
         end else begin
            s_ex <= s_id;
            s_id <= {if_valid, if_is_branch, pred_taken, idx};
         end
         if (resolve) begin
            tbl[ex_idx] <= ex_taken ? (&ex_cnt ? ex_cnt : ex_cnt + 2'd1)
                                    : (ex_cnt == 2'd0 ? ex_cnt : ex_cnt - 2'd1);
            if (!(&branch_count)) branch_count <= branch_count + CNT_W'(1);
            if (mispredict && !(&mispredict_count)) mispredict_count <= mispredict_count + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor
module tb_branch_predictor;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] if_pc = '0;
   logic        if_valid = 1'b0, if_is_branch = 1'b0, stall = 1'b0, flush = 1'b0;
   logic        ex_branch = 1'b0, ex_taken = 1'b0;
   logic        pred_taken, mispredict, redirect_to_target;
   logic [15:0] branch_count, mispredict_count;
   int          vecs = 0, errs = 0;

   branch_predictor dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_valid(if_valid), .if_is_branch(if_is_branch),
      .stall(stall), .flush(flush), .ex_branch(ex_branch), .ex_taken(ex_taken),
      .pred_taken(pred_taken), .mispredict(mispredict), .redirect_to_target(redirect_to_target),
      .branch_count(branch_count), .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one isolated branch: IF lookup, one idle cycle, then EX resolution with the given direction
   task automatic issue(input logic [31:0] pc, input logic tk, output logic p, output logic m, output logic r);
      if_pc = pc; if_valid = 1'b1; if_is_branch = 1'b1;
      #2 p = pred_taken;
      tick();
      if_valid = 1'b0; if_is_branch = 1'b0;
      tick();
      ex_branch = 1'b1; ex_taken = tk;
      #2 m = mispredict; r = redirect_to_target;
      tick();
      ex_branch = 1'b0; ex_taken = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      if_pc = 32'h40; if_valid = 1'b1; if_is_branch = 1'b1;
      #2;
      vecs++; if (pred_taken !== 1'b0) begin errs++; $display("FAIL reset_pred got %b want 0", pred_taken); end
      vecs++; if ({mispredict, redirect_to_target} !== 2'b00) begin errs++; $display("FAIL reset_mis got %b want 00", {mispredict, redirect_to_target}); end
      vecs++; if ({branch_count, mispredict_count} !== 32'h0) begin errs++; $display("FAIL reset_stats got %h/%h want 0/0", branch_count, mispredict_count); end
      if_valid = 1'b0; if_is_branch = 1'b0;
   endtask

   task automatic test_taken_train();
      logic p, m, r;
      logic [2:0] ep = 3'b110, em = 3'b001;
      for (int i = 0; i < 3; i++) begin
         issue(32'h40, 1'b1, p, m, r);
         vecs++; if (p !== ep[i]) begin errs++; $display("FAIL train_pred[%0d] got %b want %b", i, p, ep[i]); end
         vecs++; if (m !== em[i] || r !== 1'b1) begin errs++; $display("FAIL train_mis[%0d] got m=%b r=%b want m=%b r=1", i, m, r, em[i]); end
      end
      vecs++; if (branch_count !== 16'd3 || mispredict_count !== 16'd1) begin errs++; $display("FAIL train_stats got %0d/%0d want 3/1", branch_count, mispredict_count); end
   endtask

   task automatic test_not_taken();
      logic p, m, r;
      issue(32'h40, 1'b0, p, m, r);
      vecs++; if ({p, m, r} !== 3'b110) begin errs++; $display("FAIL nt_strong got p/m/r=%b want 110", {p, m, r}); end
      issue(32'h40, 1'b1, p, m, r);
      vecs++; if ({p, m, r} !== 3'b101) begin errs++; $display("FAIL nt_weak got p/m/r=%b want 101", {p, m, r}); end
      vecs++; if (branch_count !== 16'd5 || mispredict_count !== 16'd2) begin errs++; $display("FAIL nt_stats got %0d/%0d want 5/2", branch_count, mispredict_count); end
   endtask

   task automatic test_stall();
      if_pc = 32'h10; if_valid = 1'b1; if_is_branch = 1'b1;
      #2;
      vecs++; if (pred_taken !== 1'b0) begin errs++; $display("FAIL stall_pred got %b want 0", pred_taken); end
      tick();
      if_valid = 1'b0; if_is_branch = 1'b0; stall = 1'b1; ex_branch = 1'b1; ex_taken = 1'b0;
      tick(); tick();
      stall = 1'b0;
      tick();
      #2;
      vecs++; if (branch_count !== 16'd5 || mispredict !== 1'b0) begin errs++; $display("FAIL stall_early got bc=%0d m=%b want 5/0", branch_count, mispredict); end
      tick();
      ex_branch = 1'b0;
      vecs++; if (branch_count !== 16'd6 || mispredict_count !== 16'd2) begin errs++; $display("FAIL stall_count got %0d/%0d want 6/2", branch_count, mispredict_count); end
      tick();
   endtask

   task automatic test_mispredict_clear();
      logic p, m, r;
      if_pc = 32'h40; if_valid = 1'b1; if_is_branch = 1'b1;
      tick();
      if_pc = 32'h08;
      tick();
      if_valid = 1'b0; if_is_branch = 1'b0; ex_branch = 1'b1; ex_taken = 1'b0;
      #2;
      vecs++; if ({mispredict, redirect_to_target} !== 2'b10) begin errs++; $display("FAIL clr_mis got %b want 10", {mispredict, redirect_to_target}); end
      tick();
      ex_taken = 1'b1;
      #2;
      vecs++; if ({mispredict, redirect_to_target} !== 2'b11) begin errs++; $display("FAIL clr_invalid got %b want 11", {mispredict, redirect_to_target}); end
      tick();
      ex_branch = 1'b0; ex_taken = 1'b0;
      vecs++; if (branch_count !== 16'd7 || mispredict_count !== 16'd3) begin errs++; $display("FAIL clr_stats got %0d/%0d want 7/3", branch_count, mispredict_count); end
      issue(32'h08, 1'b0, p, m, r);
      vecs++; if ({p, m, r} !== 3'b000) begin errs++; $display("FAIL clr_untouched got p/m/r=%b want 000", {p, m, r}); end
   endtask

   task automatic test_alias();
      if_pc = 32'h44; if_valid = 1'b1; if_is_branch = 1'b1;
      tick();
      if_valid = 1'b0; if_is_branch = 1'b0;
      tick();
      if_pc = 32'h04; if_valid = 1'b1; if_is_branch = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1;
      #2;
      vecs++; if ({pred_taken, mispredict} !== 2'b01) begin errs++; $display("FAIL alias_same got p/m=%b want 01", {pred_taken, mispredict}); end
      tick();
      ex_branch = 1'b0; ex_taken = 1'b0;
      #2;
      vecs++; if (pred_taken !== 1'b1) begin errs++; $display("FAIL alias_next got %b want 1", pred_taken); end
      tick();
      if_valid = 1'b0; if_is_branch = 1'b0;
      tick(); tick(); tick();
      vecs++; if (branch_count !== 16'd9 || mispredict_count !== 16'd4) begin errs++; $display("FAIL alias_stats got %0d/%0d want 9/4", branch_count, mispredict_count); end
   endtask

   task automatic test_flush();
      logic p, m, r;
      if_pc = 32'h20; if_valid = 1'b1; if_is_branch = 1'b1;
      tick();
      if_pc = 32'h24;
      tick();
      if_valid = 1'b0; if_is_branch = 1'b0; ex_branch = 1'b1; ex_taken = 1'b1; flush = 1'b1;
      #2;
      vecs++; if ({mispredict, redirect_to_target} !== 2'b11) begin errs++; $display("FAIL flush_mis got %b want 11", {mispredict, redirect_to_target}); end
      tick();
      flush = 1'b0; ex_taken = 1'b0;
      #2;
      vecs++; if (mispredict !== 1'b0) begin errs++; $display("FAIL flush_after got %b want 0", mispredict); end
      tick();
      ex_branch = 1'b0;
      vecs++; if (branch_count !== 16'd10 || mispredict_count !== 16'd5) begin errs++; $display("FAIL flush_stats got %0d/%0d want 10/5", branch_count, mispredict_count); end
      issue(32'h20, 1'b1, p, m, r);
      vecs++; if ({p, m, r} !== 3'b101) begin errs++; $display("FAIL flush_update got p/m/r=%b want 101", {p, m, r}); end
   endtask

   task automatic test_back_to_back_saturation();
      int n = 0;
      if_pc = 32'h40; if_valid = 1'b1; if_is_branch = 1'b1;
      tick(); tick();
      ex_branch = 1'b1; ex_taken = 1'b1;
      while (branch_count !== 16'hFFFF && n < 70000) begin
         tick();
         n++;
      end
      vecs++; if (branch_count !== 16'hFFFF) begin errs++; $display("FAIL sat_reach got %h want ffff", branch_count); end
      tick(); tick(); tick();
      vecs++; if (branch_count !== 16'hFFFF) begin errs++; $display("FAIL sat_hold got %h want ffff", branch_count); end
      vecs++; if (mispredict_count !== 16'd5) begin errs++; $display("FAIL sat_mis got %0d want 5", mispredict_count); end
   endtask

   task automatic test_reset_midstream();
      logic p, m, r;
      rst = 1'b1;
      tick();
      rst = 1'b0; ex_branch = 1'b0; ex_taken = 1'b0;
      #2;
      vecs++; if ({branch_count, mispredict_count} !== 32'h0) begin errs++; $display("FAIL mid_stats got %h/%h want 0/0", branch_count, mispredict_count); end
      vecs++; if ({pred_taken, mispredict, redirect_to_target} !== 3'b000) begin errs++; $display("FAIL mid_out got %b want 000", {pred_taken, mispredict, redirect_to_target}); end
      tick();
      if_valid = 1'b0; if_is_branch = 1'b0;
      tick(); tick();
      issue(32'h10, 1'b1, p, m, r);
      vecs++; if ({p, m} !== 2'b01) begin errs++; $display("FAIL mid_first got p/m=%b want 01", {p, m}); end
      issue(32'h10, 1'b1, p, m, r);
      vecs++; if ({p, m} !== 2'b10) begin errs++; $display("FAIL mid_second got p/m=%b want 10", {p, m}); end
      vecs++; if (branch_count !== 16'd2 || mispredict_count !== 16'd1) begin errs++; $display("FAIL mid_count got %0d/%0d want 2/1", branch_count, mispredict_count); end
   endtask

   initial begin
      #1;
      test_reset();
      test_taken_train();
      test_not_taken();
      test_stall();
      test_mispredict_clear();
      test_alias();
      test_flush();
      test_back_to_back_saturation();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
